// File: rtl/mean_square_power.sv
// Windowed mean-square power estimator feeding the Log10 stage.
// Squares signed samples, averages 2^LOG2N of them, and holds the result in a one-word output buffer.
module mean_square_power #(
    parameter int WIS   = 4,
    parameter int WFS   = 20,
    parameter int WI    = 10,
    parameter int WF    = 40,
    parameter int LOG2N = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clear,
    input  logic [WIS+WFS-1:0]   SampleIn,
    input  logic                 InValid,
    output logic [WI+WF-1:0]     NumOut,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 ZeroFlag,
    output logic                 Overrun
);

    localparam int SW  = WIS + WFS;
    localparam int PW  = 2 * SW;
    localparam int AW  = PW + LOG2N;
    localparam int OW  = WI + WF;
    localparam int PAD = WF - 2 * WFS;
    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [PW-1:0] square(input logic signed [SW-1:0] x);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] p;
        xe = PW'(x);
        p  = xe * xe;
        return $unsigned(p);
    endfunction

    // Truncating divide by N, then placed so the fraction lines up with WF bits.
    function automatic logic [OW-1:0] format_mean(input logic [AW-1:0] total_in);
        logic [OW-1:0] r;
        r = '0;
        r[PAD +: PW] = total_in[AW-1:LOG2N];
        return r;
    endfunction

    logic signed [SW-1:0] sample;
    logic [PW-1:0]        sq_p1;
    logic                 vld_p1;
    logic [AW-1:0]        acc_p2;
    logic [LOG2N-1:0]     cnt_p2;
    logic [AW-1:0]        total;
    logic [OW-1:0]        mean_word;
    logic                 win_end;
    state_t               state_q;
    state_t               state_d;
    logic                 load;
    logic                 drop;

    assign sample = SampleIn;

    // ---- stage 1: square ----
    always_ff @(posedge Clk) begin
        sq_p1 <= square(sample);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= InValid && !Clear;
        end
    end

    // ---- stage 2: accumulate; the last sample of a window bypasses acc ----
    assign total     = acc_p2 + AW'(sq_p1);
    assign mean_word = format_mean(total);
    assign win_end   = vld_p1 && !Clear && (cnt_p2 == CNT_LAST);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
        end else if (Clear || win_end) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
        end else if (vld_p1) begin
            acc_p2 <= total;
            cnt_p2 <= cnt_p2 + LOG2N'(1);
        end
    end

    // ---- output buffer ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (win_end) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (win_end) begin
                    load = OutReady;
                    drop = !OutReady;
                end else if (OutReady) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            NumOut   <= '0;
            ZeroFlag <= 1'b0;
        end else if (load) begin
            NumOut   <= mean_word;
            ZeroFlag <= (mean_word == '0);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Overrun <= 1'b0;
        end else if (drop) begin
            Overrun <= 1'b1;
        end
    end

    assign OutValid = (state_q == FULL);

endmodule

// File: tb/tb_mean_square_power.sv
// Randomised and directed bench for mean_square_power with a window-level reference model.
module tb_mean_square_power;

    localparam int WIS   = 4;
    localparam int WFS   = 20;
    localparam int WI    = 10;
    localparam int WF    = 40;
    localparam int LOG2N = 4;
    localparam int SW    = WIS + WFS;
    localparam int OW    = WI + WF;
    localparam int N     = 1 << LOG2N;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Clear;
    logic [SW-1:0] SampleIn;
    logic          InValid;
    logic [OW-1:0] NumOut;
    logic          OutValid;
    logic          OutReady;
    logic          ZeroFlag;
    logic          Overrun;

    mean_square_power #(
        .WIS(WIS), .WFS(WFS), .WI(WI), .WF(WF), .LOG2N(LOG2N)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Clear(Clear), .SampleIn(SampleIn), .InValid(InValid),
        .NumOut(NumOut), .OutValid(OutValid), .OutReady(OutReady),
        .ZeroFlag(ZeroFlag), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference: samples of the open window, a finished window in flight, and the output buffer.
    longint win_sum;
    int     win_cnt;
    bit     pend_v;
    longint pend_w;
    bit     buf_v;
    longint buf_w;
    bit     ovr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        win_sum = 0; win_cnt = 0;
        pend_v = 0; pend_w = 0;
        buf_v = 0; buf_w = 0;
        ovr = 0;
    endtask

    function automatic longint word_of(input longint sum);
        return (sum >>> LOG2N) <<< (WF - 2 * WFS);
    endfunction

    // Called just after a falling edge: drive one cycle, advance model, check after the rising edge.
    task automatic step(input bit iv, input logic [SW-1:0] s, input bit clr, input bit rdy);
        longint ss;
        bit arriving;
        InValid  = iv;
        SampleIn = s;
        Clear    = clr;
        OutReady = rdy;

        arriving = pend_v && !clr;
        if (buf_v && rdy) buf_v = 0;
        if (arriving) begin
            if (buf_v) ovr = 1;
            else begin
                buf_v = 1;
                buf_w = pend_w;
            end
        end
        pend_v = 0;
        if (clr) begin
            win_sum = 0;
            win_cnt = 0;
        end else if (iv) begin
            ss = longint'($signed(s));
            win_sum += ss * ss;
            win_cnt++;
            if (win_cnt == N) begin
                pend_v  = 1;
                pend_w  = word_of(win_sum);
                win_sum = 0;
                win_cnt = 0;
            end
        end

        @(posedge Clk);
        #1;
        check("out_valid", 64'(OutValid), 64'(buf_v));
        if (buf_v) begin
            check("num_out", 64'(NumOut), 64'(buf_w));
            check("zero_flag", 64'(ZeroFlag), 64'(buf_w == 0));
        end
        check("overrun", 64'(Overrun), 64'(ovr));
        @(negedge Clk);
    endtask

    task automatic window(input logic [SW-1:0] s, input bit rdy);
        for (int i = 0; i < N; i++) step(1'b1, s, 1'b0, rdy);
    endtask

    initial begin
        logic [SW-1:0] one, three, half, two_p, two_n, neg8;
        one   = 24'h100000;
        three = 24'h300000;
        half  = 24'h080000;
        two_p = 24'h200000;
        two_n = 24'hE00000;
        neg8  = 24'h800000;

        Rst = 1'b0; Clear = 1'b0; InValid = 1'b0; SampleIn = '0; OutReady = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        check("rst_num_out", 64'(NumOut), 64'd0);
        check("rst_out_valid", 64'(OutValid), 64'd0);
        check("rst_zero_flag", 64'(ZeroFlag), 64'd0);
        check("rst_overrun", 64'(Overrun), 64'd0);
        Rst = 1'b1;

        // 16 x 1.0: result appears two cycles after the last sample, for one cycle
        window(one, 1'b1);
        check("t1_lat_early", 64'(OutValid), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t1_valid", 64'(OutValid), 64'd1);
        check("t1_num", 64'(NumOut), 64'd1 << 40);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t1_consumed", 64'(OutValid), 64'd0);

        // +/-2.0 alternating with idle gaps
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, '0, 1'b0, 1'b1);
            step(1'b1, (i % 2 == 0) ? two_p : two_n, 1'b0, 1'b1);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        check("t2_num", 64'(NumOut), 64'd4 << 40);
        check("t2_zero", 64'(ZeroFlag), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        // full-scale negative
        window(neg8, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t3_num", 64'(NumOut), 64'd64 << 40);
        check("t3_msb", 64'(NumOut[OW-1]), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        // zero power
        window('0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t4_valid", 64'(OutValid), 64'd1);
        check("t4_zero", 64'(ZeroFlag), 64'd1);
        check("t4_num", 64'(NumOut), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        // consumer stalled across two windows
        window(one, 1'b0);
        window(three, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t5_num_kept", 64'(NumOut), 64'd1 << 40);
        check("t5_overrun", 64'(Overrun), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t5_drained", 64'(OutValid), 64'd0);

        // Clear after seven samples, then a clean window of 0.5
        for (int i = 0; i < 7; i++) step(1'b1, one, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        window(half, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t6_num", 64'(NumOut), 64'd1 << 38);
        step(1'b0, '0, 1'b0, 1'b1);

        // Clear coinciding with window end suppresses the result
        window(one, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t7_suppressed", 64'(OutValid), 64'd0);

        // asynchronous reset mid-window with a full buffer and Overrun set
        window(one, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, three, 1'b0, 1'b0);
        #2;
        Rst = 1'b0;
        #1;
        check("mid_rst_num", 64'(NumOut), 64'd0);
        check("mid_rst_valid", 64'(OutValid), 64'd0);
        check("mid_rst_zero", 64'(ZeroFlag), 64'd0);
        check("mid_rst_ovr", 64'(Overrun), 64'd0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), SW'($urandom()),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
